vga7seg_display: RTL and testbench

- VGA 640x480@60 timing generator that draws one large seven-segment digit on screen, driven by a 7-bit segment vector.
- Sits between a digit/segment decoder and the VGA connector.
- Outputs active-low h_sync and v_sync, plus a 4-bit pixel intensity.
- Advances one pixel per enabled clock; ce is the pixel-clock enable.

---
 rtl/vga7seg_display.sv | 124 ++++++++++++
 tb/tb_vga7seg_display.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga7seg_display.sv
// 640x480@60 VGA timing generator that paints one large seven-segment digit.
// Define VGA7SEG_FRAME_LATCH_EN to sample seg once per frame (tear-free) instead of live.
module vga7seg_display #(
    parameter int H_DISPLAY_TIME = 640,
    parameter int H_PULSE_WIDTH  = 96,
    parameter int H_FRONT_PORCH  = 16,
    parameter int H_BACK_PORCH   = 48,
    parameter int H_SYNC_PULSE   = H_DISPLAY_TIME + H_PULSE_WIDTH + H_FRONT_PORCH + H_BACK_PORCH,
    parameter int V_DISPLAY_TIME = 480,
    parameter int V_PULSE_WIDTH  = 2,
    parameter int V_FRONT_PORCH  = 10,
    parameter int V_BACK_PORCH   = 29,
    parameter int V_SYNC_PULSE   = V_DISPLAY_TIME + V_PULSE_WIDTH + V_FRONT_PORCH + V_BACK_PORCH,
    parameter int HALF_WIDTH     = 15,
    parameter int HALF_LENGTH    = 60,
    parameter int H_POS          = 400,
    parameter int V_POS          = 320
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg,
    input  logic       ce,
    output logic       h_sync,
    output logic       v_sync,
    output logic [3:0] pixel
);

    localparam logic [9:0]  H_LAST = 10'(H_SYNC_PULSE - 1);
    localparam logic [9:0]  V_LAST = 10'(V_SYNC_PULSE - 1);
    localparam logic [11:0] H_VIS  = 12'(H_DISPLAY_TIME);
    localparam logic [11:0] V_VIS  = 12'(V_DISPLAY_TIME);
    localparam logic [11:0] HS_LO  = 12'(H_DISPLAY_TIME + H_FRONT_PORCH);
    localparam logic [11:0] HS_HI  = 12'(H_DISPLAY_TIME + H_FRONT_PORCH + H_PULSE_WIDTH);
    localparam logic [11:0] VS_LO  = 12'(V_DISPLAY_TIME + V_FRONT_PORCH);
    localparam logic [11:0] VS_HI  = 12'(V_DISPLAY_TIME + V_FRONT_PORCH + V_PULSE_WIDTH);

    logic [9:0]  r_hc;
    logic [9:0]  r_vc;
    logic        r_h_sync;
    logic        r_v_sync;
    logic [3:0]  r_pixel;

    logic [11:0] w_x;
    logic [11:0] w_y;
    logic [6:0]  w_seg;
    logic [6:0]  w_hit;
    logic        w_visible;
    logic        w_hs_next;
    logic        w_vs_next;
    logic [3:0]  w_pixel_next;

    // Widen before comparing so that rectangle edges near zero never wrap.
    assign w_x = {2'b00, r_hc};
    assign w_y = {2'b00, r_vc};

`ifdef VGA7SEG_FRAME_LATCH_EN
    logic [6:0] r_seg_frame;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_frame <= 7'b0000000;
        end else if (ce && (r_hc == 10'd0) && (r_vc == 10'd0)) begin
            r_seg_frame <= seg;
        end
    end

    assign w_seg = r_seg_frame;
`else
    assign w_seg = seg;
`endif

    // One rectangle per segment; bit index follows seg[6]=a ... seg[0]=g.
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_seg
            localparam bit HORIZ = (gi == 6) || (gi == 3) || (gi == 0);
            localparam int CX = HORIZ ? H_POS :
                                (((gi == 5) || (gi == 4)) ? H_POS + HALF_LENGTH : H_POS - HALF_LENGTH);
            localparam int CY = (gi == 6) ? V_POS - 2 * HALF_LENGTH :
                                (gi == 3) ? V_POS + 2 * HALF_LENGTH :
                                (gi == 0) ? V_POS :
                                (((gi == 5) || (gi == 1)) ? V_POS - HALF_LENGTH : V_POS + HALF_LENGTH);
            localparam int HX = HORIZ ? HALF_LENGTH : HALF_WIDTH;
            localparam int HY = HORIZ ? HALF_WIDTH : HALF_LENGTH;
            localparam logic [11:0] X_LO = 12'(CX - HX);
            localparam logic [11:0] X_HI = 12'(CX + HX);
            localparam logic [11:0] Y_LO = 12'(CY - HY);
            localparam logic [11:0] Y_HI = 12'(CY + HY);

            assign w_hit[gi] = w_seg[gi] && (w_x >= X_LO) && (w_x < X_HI)
                                         && (w_y >= Y_LO) && (w_y < Y_HI);
        end
    endgenerate

    assign w_visible    = (w_x < H_VIS) && (w_y < V_VIS);
    assign w_hs_next    = !((w_x >= HS_LO) && (w_x < HS_HI));
    assign w_vs_next    = !((w_y >= VS_LO) && (w_y < VS_HI));
    assign w_pixel_next = (w_visible && (|w_hit)) ? 4'hF : 4'h0;

    // Outputs trail the counters by one enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hc     <= 10'd0;
            r_vc     <= 10'd0;
            r_h_sync <= 1'b1;
            r_v_sync <= 1'b1;
            r_pixel  <= 4'h0;
        end else if (ce) begin
            r_h_sync <= w_hs_next;
            r_v_sync <= w_vs_next;
            r_pixel  <= w_pixel_next;
            if (r_hc == H_LAST) begin
                r_hc <= 10'd0;
                r_vc <= (r_vc == V_LAST) ? 10'd0 : r_vc + 10'd1;
            end else begin
                r_hc <= r_hc + 10'd1;
            end
        end
    end

    assign h_sync = r_h_sync;
    assign v_sync = r_v_sync;
    assign pixel  = r_pixel;

endmodule

// File: tb/tb_vga7seg_display.sv
// Bench for vga7seg_display: a full-size instance for sync timing and a scaled-down
// instance whose whole frame fits in a few thousand cycles, both checked against a raster model.
module tb_vga7seg_display;

    // Scaled geometry for the second instance.
    localparam int S_HD = 64, S_HFP = 4, S_HPW = 8, S_HBP = 4;
    localparam int S_VD = 48, S_VFP = 2, S_VPW = 2, S_VBP = 3;
    localparam int S_HW = 2, S_HL = 6, S_HP = 30, S_VP = 24;

    typedef struct {
        int hd; int hfp; int hpw; int hbp;
        int vd; int vfp; int vpw; int vbp;
        int hw; int hl; int hp; int vp;
    } geom_t;

    typedef struct {
        logic [6:0] seg;
        int         x;
        int         y;
        logic [3:0] px;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic [6:0] seg;
    logic       hs0, vs0, hs1, vs1;
    logic [3:0] px0, px1;

    geom_t      G [2];
    int         m_p   [2];
    logic       m_hs  [2];
    logic       m_vs  [2];
    logic [3:0] m_px  [2];
    logic [6:0] m_lat [2];
    int         m_lx  [2];
    int         m_ly  [2];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    vga7seg_display dut (
        .clk(clk), .rst(rst), .seg(seg), .ce(ce),
        .h_sync(hs0), .v_sync(vs0), .pixel(px0)
    );

    vga7seg_display #(
        .H_DISPLAY_TIME(S_HD), .H_PULSE_WIDTH(S_HPW), .H_FRONT_PORCH(S_HFP), .H_BACK_PORCH(S_HBP),
        .V_DISPLAY_TIME(S_VD), .V_PULSE_WIDTH(S_VPW), .V_FRONT_PORCH(S_VFP), .V_BACK_PORCH(S_VBP),
        .HALF_WIDTH(S_HW), .HALF_LENGTH(S_HL), .H_POS(S_HP), .V_POS(S_VP)
    ) dut_s (
        .clk(clk), .rst(rst), .seg(seg), .ce(ce),
        .h_sync(hs1), .v_sync(vs1), .pixel(px1)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Is (x,y) inside segment idx's rectangle (seg[6]=a ... seg[0]=g)?
    function automatic bit seg_lit(int g, int idx, int x, int y);
        int l, w, cx, cy;
        bit horiz;
        l = G[g].hl;
        w = G[g].hw;
        cx = G[g].hp;
        cy = G[g].vp;
        horiz = 1'b0;
        case (idx)
            6: begin horiz = 1'b1; cy = G[g].vp - 2 * l; end
            0: begin horiz = 1'b1; cy = G[g].vp; end
            3: begin horiz = 1'b1; cy = G[g].vp + 2 * l; end
            5: begin cx = G[g].hp + l; cy = G[g].vp - l; end
            4: begin cx = G[g].hp + l; cy = G[g].vp + l; end
            2: begin cx = G[g].hp - l; cy = G[g].vp + l; end
            default: begin cx = G[g].hp - l; cy = G[g].vp - l; end
        endcase
        if (horiz)
            return (x >= cx - l) && (x < cx + l) && (y >= cy - w) && (y < cy + w);
        return (x >= cx - w) && (x < cx + w) && (y >= cy - l) && (y < cy + l);
    endfunction

    // Raster model: a linear pixel index per frame, outputs derived from the layout rules.
    task automatic model_step();
        for (int g = 0; g < 2; g++) begin
            int ht, vt, x, y, hs_start, vs_start;
            logic [6:0] segu;
            bit lit;
            if (rst) begin
                m_p[g] = 0; m_hs[g] = 1'b1; m_vs[g] = 1'b1; m_px[g] = 4'h0;
                m_lat[g] = 7'b0; m_lx[g] = -1; m_ly[g] = -1;
            end else if (ce) begin
                ht = G[g].hd + G[g].hfp + G[g].hpw + G[g].hbp;
                vt = G[g].vd + G[g].vfp + G[g].vpw + G[g].vbp;
                x = m_p[g] % ht;
                y = m_p[g] / ht;
`ifdef VGA7SEG_FRAME_LATCH_EN
                segu = m_lat[g];
                if (m_p[g] == 0) m_lat[g] = seg;
`else
                segu = seg;
`endif
                hs_start = G[g].hd + G[g].hfp;
                vs_start = G[g].vd + G[g].vfp;
                m_hs[g] = !((x >= hs_start) && (x < hs_start + G[g].hpw));
                m_vs[g] = !((y >= vs_start) && (y < vs_start + G[g].vpw));
                lit = 1'b0;
                for (int i = 0; i < 7; i++)
                    if (segu[i] && seg_lit(g, i, x, y)) lit = 1'b1;
                m_px[g] = (x < G[g].hd && y < G[g].vd && lit) ? 4'hF : 4'h0;
                m_lx[g] = x;
                m_ly[g] = y;
                m_p[g]  = (m_p[g] + 1) % (ht * vt);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_step();
        check("hs_full", hs0, m_hs[0]);
        check("vs_full", vs0, m_vs[0]);
        check("px_full", px0, m_px[0]);
        check("hs_small", hs1, m_hs[1]);
        check("vs_small", vs1, m_vs[1]);
        check("px_small", px1, m_px[1]);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl [14];
        logic [6:0] cur_seg;
        int n, lowc, highc, tgl;

        G[0] = '{640, 16, 96, 48, 480, 10, 2, 29, 15, 60, 400, 320};
        G[1] = '{S_HD, S_HFP, S_HPW, S_HBP, S_VD, S_VFP, S_VPW, S_VBP, S_HW, S_HL, S_HP, S_VP};

        // Scaled digit: a x[24,36) y[10,14); g y[22,26); d y[34,38);
        // b,c x[34,38); e,f x[22,26); b,f y[12,24); c,e y[24,36).
        tbl[0]  = '{7'b1110000, 70,  5, 4'h0};  // horizontal blanking
        tbl[1]  = '{7'b1110000, 30, 12, 4'hF};  // a
        tbl[2]  = '{7'b1110000, 24, 18, 4'h0};  // f off
        tbl[3]  = '{7'b1110000, 36, 18, 4'hF};  // b
        tbl[4]  = '{7'b1110000, 30, 24, 4'h0};  // g off
        tbl[5]  = '{7'b1110000, 36, 30, 4'hF};  // c
        tbl[6]  = '{7'b1111111, 23, 11, 4'h0};  // left of a
        tbl[7]  = '{7'b1111111, 24, 11, 4'hF};  // a left edge
        tbl[8]  = '{7'b1111111, 35, 11, 4'hF};  // a last column
        tbl[9]  = '{7'b1111111, 36, 11, 4'h0};  // right of a, above b
        tbl[10] = '{7'b1111111, 36, 12, 4'hF};  // b top edge
        tbl[11] = '{7'b1111111, 25, 25, 4'hF};  // e/g overlap
        tbl[12] = '{7'b1111111, 30, 37, 4'hF};  // d last row
        tbl[13] = '{7'b1111111, 30, 38, 4'h0};  // below d

        // Reset held with ce=1 and random segments
        rst = 1'b1; ce = 1'b1; seg = 7'b0;
        for (int i = 0; i < 50; i++) begin
            seg = 7'($urandom);
            tick();
        end
        check("reset_hs", hs0, 1);
        check("reset_px", px0, 0);
        $display("reset: 50 cycles held, h_sync=%0d v_sync=%0d pixel=%0h", hs0, vs0, px0);

        // Horizontal timing of the full-size instance
        rst = 1'b0; seg = 7'b1110000;
        n = 0;
        do begin tick(); n++; end while (hs0 == 1'b1 && n < 2000);
        check("hs_first_fall", n, 657);
        lowc = 0;
        do begin tick(); lowc++; end while (hs0 == 1'b0 && lowc < 2000);
        check("hs_low_width", lowc, 96);
        highc = 0;
        do begin tick(); highc++; end while (hs0 == 1'b1 && highc < 2000);
        check("hs_period", lowc + highc, 800);
        $display("hsync: first fall %0d, low %0d, period %0d", n, lowc, lowc + highc);

        // Table of pixel probes on the scaled instance
        cur_seg = 7'bx;
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].seg !== cur_seg) begin
                cur_seg = tbl[i].seg;
                seg = cur_seg;
                n = 0;
                do begin tick(); n++; end while (!(m_lx[1] == 0 && m_ly[1] == 0) && n < 10000);
            end
            n = 0;
            do begin tick(); n++; end while (!(m_lx[1] == tbl[i].x && m_ly[1] == tbl[i].y) && n < 10000);
            if (n >= 10000)
                check("table_reach", 0, 1);
            else
                check($sformatf("table_vec%0d", i), px1, tbl[i].px);
            $display("vec %0d: seg=%b (%0d,%0d) pixel=%0h want %0h", i, tbl[i].seg,
                     tbl[i].x, tbl[i].y, px1, tbl[i].px);
        end

        // Vertical timing of the scaled instance: sync on lines 50..51 of 55
        rst = 1'b1; tick(); rst = 1'b0;
        n = 0;
        do begin tick(); n++; end while (vs1 == 1'b1 && n < 10000);
        check("vs_first_fall", n, 50 * 80 + 1);
        lowc = 0;
        do begin tick(); lowc++; end while (vs1 == 1'b0 && lowc < 10000);
        check("vs_low_width", lowc, 160);
        highc = 0;
        do begin tick(); highc++; end while (vs1 == 1'b1 && highc < 10000);
        check("vs_period", lowc + highc, 4400);
        $display("vsync: first fall %0d, low %0d, period %0d", n, lowc, lowc + highc);

        // ce toggling every cycle doubles the line length in clocks
        rst = 1'b1; tick(); rst = 1'b0;
        tgl = 0; n = 0;
        do begin ce = (tgl % 2 == 0); tgl++; tick(); n++; end while (hs0 == 1'b1 && n < 4000);
        check("ce_hs_first_fall", n, 1313);
        lowc = 0;
        do begin ce = (tgl % 2 == 0); tgl++; tick(); lowc++; end while (hs0 == 1'b0 && lowc < 4000);
        highc = 0;
        do begin ce = (tgl % 2 == 0); tgl++; tick(); highc++; end while (hs0 == 1'b1 && highc < 4000);
        check("ce_line_clocks", lowc + highc, 1600);
        $display("ce gating: first fall %0d clocks, line %0d clocks", n, lowc + highc);

        // Reset mid-line while ce=0, h_sync currently low
        ce = 1'b0; rst = 1'b1;
        tick();
        check("rst_ce0_hs", hs0, 1);
        check("rst_ce0_px", px1, 0);
        $display("reset with ce=0: h_sync=%0d pixel=%0h", hs0, px1);
        rst = 1'b0;

        // Randomized traffic checked cycle by cycle against the model
        seg = 7'($urandom);
        for (int i = 0; i < 18000; i++) begin
            ce  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 4999) == 0);
            if ($urandom_range(0, 199) == 0) seg = 7'($urandom);
            tick();
        end
        $display("random: 18000 cycles compared");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
